// File: rtl/spi_display_controller.sv
// SPI-slave command controller for the 4 LEDs and the single 7-seg digit, with a 0-F self-test fallback.
// Optional feature: define SPI_DISPLAY_ECHO_EN to make miso echo the last decoded command byte.
module spi_display_controller #(
  parameter int TICK_DIV     = 399_999,
  parameter int IDLE_TIMEOUT = 8,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       FPGA_clk,
  input  logic       FPGA_reset,
  input  logic       arduino_sclk,
  input  logic       arduino_mosi,
  input  logic       arduino_ss_n,
  output logic       fpga_physical_miso,
  output logic [3:0] display_value,
  output logic       display_blank,
  output logic [3:0] led_value,
  output logic       mode_selftest,
  output logic       frame_err
);
  localparam int DIV_W = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
  localparam int TMO_W = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DECODE = 2'd2} state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_ss_sync;
  logic                   r_sclk_d, r_ss_d;
  state_t                 r_state;
  logic [7:0]             r_shift;
  logic [3:0]             r_bit_cnt;
  logic                   r_overrun;
  logic [6:0]             r_tx;
  logic                   r_miso;
  logic [DIV_W-1:0]       r_div;
  logic [3:0]             r_count;
  logic [TMO_W-1:0]       r_tmo;
  logic [3:0]             r_disp, r_led;
  logic                   r_blank, r_selftest, r_ferr;
`ifdef SPI_DISPLAY_ECHO_EN
  logic [7:0]             r_echo;
`endif

  logic       w_sclk, w_mosi, w_ss;
  logic       w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall;
  logic       w_tick, w_valid_dec;
  logic [3:0] w_count_nxt;
  logic [7:0] w_tx_load;

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_ss        = r_ss_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_ss_rise   = w_ss & ~r_ss_d;
  assign w_ss_fall   = ~w_ss & r_ss_d;
  assign w_tick      = (r_div == DIV_MAX);
  assign w_count_nxt = r_count + 4'd1;
  assign w_valid_dec = (r_state == S_DECODE) && (r_shift[7:4] >= 4'h1) && (r_shift[7:4] <= 4'h5);
`ifdef SPI_DISPLAY_ECHO_EN
  assign w_tx_load   = r_echo;
`else
  assign w_tx_load   = {r_selftest, r_ferr, r_blank, 1'b0, r_disp};
`endif

  // Synchronisers reset low so a frame already open at reset release never produces an ss_n fall.
  always_ff @(posedge FPGA_clk or posedge FPGA_reset) begin
    if (FPGA_reset) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_ss_sync   <= '0;
      r_sclk_d    <= 1'b0;
      r_ss_d      <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], arduino_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], arduino_mosi};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], arduino_ss_n};
      r_sclk_d    <= w_sclk;
      r_ss_d      <= w_ss;
    end
  end

  // Frame FSM, tick divider, self-test count, idle timeout and display registers.
  always_ff @(posedge FPGA_clk or posedge FPGA_reset) begin
    if (FPGA_reset) begin
      r_state    <= S_IDLE;
      r_shift    <= 8'h00;
      r_bit_cnt  <= 4'd0;
      r_overrun  <= 1'b0;
      r_tx       <= 7'h00;
      r_miso     <= 1'b0;
      r_div      <= '0;
      r_count    <= 4'd0;
      r_tmo      <= '0;
      r_disp     <= 4'd0;
      r_led      <= 4'd0;
      r_blank    <= 1'b0;
      r_selftest <= 1'b0;
      r_ferr     <= 1'b0;
`ifdef SPI_DISPLAY_ECHO_EN
      r_echo     <= 8'h00;
`endif
    end else begin
      r_div <= w_tick ? '0 : r_div + DIV_W'(1);
      if (w_tick) begin
        r_count <= w_count_nxt;
      end
      if (w_tick && r_selftest) begin
        r_disp <= w_count_nxt;
        r_led  <= w_count_nxt;
      end
      // A valid frame in the same cycle as expiry wins, so expiry is only evaluated without one.
      if (w_valid_dec) begin
        r_tmo <= '0;
      end else if ((IDLE_TIMEOUT != 0) && w_tick && (r_tmo != TMO_MAX)) begin
        r_tmo <= r_tmo + TMO_W'(1);
        if ((r_tmo + TMO_W'(1)) == TMO_MAX) begin
          r_selftest <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          r_miso <= 1'b0;
          if (w_ss_fall) begin
            r_state   <= S_SHIFT;
            r_bit_cnt <= 4'd0;
            r_overrun <= 1'b0;
            r_tx      <= w_tx_load[6:0];
            r_miso    <= w_tx_load[7];
          end
        end
        S_SHIFT: begin
          if (w_ss_rise) begin
            r_miso <= 1'b0;
            if ((r_bit_cnt == 4'd8) && !r_overrun) begin
              r_state <= S_DECODE;
            end else begin
              r_ferr  <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            if (w_sclk_rise) begin
              r_shift <= {r_shift[6:0], w_mosi};
              if (r_bit_cnt == 4'd8) begin
                r_overrun <= 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
            if (w_sclk_fall) begin
              r_tx   <= {r_tx[5:0], 1'b0};
              r_miso <= r_tx[6];
            end
          end
        end
        S_DECODE: begin
          r_state <= S_IDLE;
          r_miso  <= 1'b0;
          case (r_shift[7:4])
            4'h1: begin
              r_disp     <= r_shift[3:0];
              r_selftest <= 1'b0;
            end
            4'h2: begin
              r_led      <= r_shift[3:0];
              r_selftest <= 1'b0;
            end
            4'h3: r_blank <= r_shift[0];
            4'h4: begin
              r_selftest <= r_shift[0];
              if (r_shift[0]) begin
                r_count <= 4'd0;
              end
            end
            4'h5: r_ferr <= 1'b0;
            default: r_ferr <= 1'b1;
          endcase
`ifdef SPI_DISPLAY_ECHO_EN
          if (w_valid_dec) begin
            r_echo <= r_shift;
          end
`endif
        end
        default: begin
          r_state <= S_IDLE;
          r_miso  <= 1'b0;
        end
      endcase
    end
  end

  assign fpga_physical_miso = r_miso;
  assign display_value      = r_disp;
  assign display_blank      = r_blank;
  assign led_value          = r_led;
  assign mode_selftest      = r_selftest;
  assign frame_err          = r_ferr;
endmodule
